pc_redirect_unit: RTL

//  Program-counter register and fetch-redirect controller sitting directly downstream of the

---
 rtl/pc_redirect_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_redirect_unit: PC register with taken-branch redirect and timed IF/ID   |
// | flush, misaligned-target flag and debug redirect counter.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchValid,
  input  logic             ZeroFlag,
  input  logic [31:0]      Target,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             FlushIFID,
  output logic             Redirect,
  output logic             AddrErr,
  output logic [CNT_W-1:0] TakenCount
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_FLUSH    = 1'b1;
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       flush_cnt_q, flush_cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             redirect_q, redirect_d;
  logic             addr_err_q, addr_err_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             w_accept;
  logic [31:0]      w_pc_plus4;

  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_accept   = (state_q == S_IDLE) && !Stall && BranchValid && ZeroFlag;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_d        = pc_q;
    flush_d     = flush_q;
    redirect_d  = 1'b0;
    addr_err_d  = 1'b0;
    taken_cnt_d = taken_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Stall) begin
          pc_d = pc_q;
        end else if (w_accept) begin
          pc_d        = {Target[31:2], 2'b00};
          redirect_d  = 1'b1;
          addr_err_d  = |Target[1:0];
          taken_cnt_d = taken_cnt_q + CNT_W'(1);
          state_d     = S_FLUSH;
          flush_cnt_d = FLUSH_INIT;
          flush_d     = 1'b1;
        end else begin
          pc_d = w_pc_plus4;
        end
      end
      S_FLUSH: begin
        // Decode holds a squashed instruction here, so its requests are ignored.
        pc_d = w_pc_plus4;
        if (flush_cnt_q == 2'd0) begin
          state_d = S_IDLE;
          flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        flush_cnt_d = 2'd0;
        flush_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= 2'd0;
      pc_q        <= RESET_PC;
      flush_q     <= 1'b0;
      redirect_q  <= 1'b0;
      addr_err_q  <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pc_q        <= pc_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      addr_err_q  <= addr_err_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign PC         = pc_q;
  assign PCPlus4    = w_pc_plus4;
  assign FlushIFID  = flush_q;
  assign Redirect   = redirect_q;
  assign AddrErr    = addr_err_q;
  assign TakenCount = taken_cnt_q;

endmodule
`default_nettype wire
